// File: rtl/hps_dma_bridge.sv
// Bridges single-word HPS DMA requests onto an Avalon-MM master port.
// Reads go through a one-line prefetch buffer. Writes are single-beat and write through.
module hps_dma_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BURST  = 8
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                dma_rd,
  input  logic                dma_wr,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_dout,
  output logic [DATA_W-1:0]   dma_din,
  output logic                io_wait,
  input  logic                flush,
  output logic [15:0]         hit_cnt,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [6:0]          avm_burstcount,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam int IDX   = $clog2(BURST);
  localparam int IDX_W = (IDX > 0) ? IDX : 1;
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [WA_W-1:0]  LINE_MASK = ~WA_W'(BURST - 1);
  localparam logic [IDX_W-1:0] IDX_MASK  = IDX_W'(BURST - 1);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST - 1);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_REQ} state_t;

  state_t             state_reg, state_next;
  logic [WA_W-1:0]    addr_reg;
  logic [WA_W-1:0]    tag_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [DATA_W-1:0]  dout_reg;
  logic [IDX_W-1:0]   beat_cnt_reg;
  logic [15:0]        hit_cnt_reg;
  logic               valid_reg;
  logic               flush_pending_reg;
  logic [DATA_W-1:0]  line_mem [BURST];

  logic [WA_W-1:0]    req_word, req_line, lat_line;
  logic [IDX_W-1:0]   req_idx, lat_idx;
  logic               rd_hit, wr_hit, last_beat;
  logic               unused_ok;

  // Tags are kept as full word addresses with the in-line index bits masked off.
  assign req_word  = dma_addr[ADDR_W-1:2];
  assign req_line  = req_word & LINE_MASK;
  assign req_idx   = req_word[IDX_W-1:0] & IDX_MASK;
  assign lat_line  = addr_reg & LINE_MASK;
  assign lat_idx   = addr_reg[IDX_W-1:0] & IDX_MASK;
  assign rd_hit    = valid_reg && (req_line == tag_reg) && !flush;
  assign wr_hit    = valid_reg && (lat_line == tag_reg);
  assign last_beat = avm_readdatavalid && (beat_cnt_reg == LAST_BEAT);
  assign unused_ok = &{1'b0, dma_addr[1:0]};

  always_ff @(posedge clk_sys) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (dma_wr)                 state_next = WR_REQ;
        else if (dma_rd && !rd_hit) state_next = RD_REQ;
      end
      RD_REQ:  if (!avm_waitrequest) state_next = RD_DATA;
      RD_DATA: if (last_beat)        state_next = IDLE;
      WR_REQ:  if (!avm_waitrequest) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    io_wait        = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = {addr_reg, 2'b00};
    avm_burstcount = 7'd1;
    case (state_reg)
      RD_REQ: begin
        io_wait        = 1'b1;
        avm_read       = 1'b1;
        avm_address    = {lat_line, 2'b00};
        avm_burstcount = 7'(BURST);
      end
      RD_DATA: io_wait = 1'b1;
      WR_REQ: begin
        io_wait   = 1'b1;
        avm_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign avm_writedata  = wdata_reg;
  assign avm_byteenable = '1;
  assign dma_din        = dout_reg;
  assign hit_cnt        = hit_cnt_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      addr_reg          <= '0;
      tag_reg           <= '0;
      wdata_reg         <= '0;
      dout_reg          <= '0;
      beat_cnt_reg      <= '0;
      hit_cnt_reg       <= '0;
      valid_reg         <= 1'b0;
      flush_pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush) valid_reg <= 1'b0;
          if (dma_wr) begin
            addr_reg  <= req_word;
            wdata_reg <= dma_dout;
          end else if (dma_rd) begin
            if (rd_hit) begin
              dout_reg <= line_mem[req_idx];
              if (hit_cnt_reg != 16'hFFFF) hit_cnt_reg <= hit_cnt_reg + 16'd1;
            end else begin
              addr_reg          <= req_word;
              valid_reg         <= 1'b0;
              beat_cnt_reg      <= '0;
              flush_pending_reg <= 1'b0;
            end
          end
        end
        RD_REQ: if (flush) flush_pending_reg <= 1'b1;
        RD_DATA: begin
          if (flush) flush_pending_reg <= 1'b1;
          if (avm_readdatavalid) beat_cnt_reg <= beat_cnt_reg + 1'b1;
          if (last_beat) begin
            // The requested word may be the beat arriving this very cycle.
            dout_reg          <= (lat_idx == beat_cnt_reg) ? avm_readdata : line_mem[lat_idx];
            valid_reg         <= !(flush_pending_reg || flush);
            tag_reg           <= lat_line;
            flush_pending_reg <= 1'b0;
          end
        end
        WR_REQ: if (flush) valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  // Line storage is left unreset; valid_reg alone decides whether it is usable.
  always_ff @(posedge clk_sys) begin
    if (state_reg == RD_DATA && avm_readdatavalid)
      line_mem[beat_cnt_reg] <= avm_readdata;
    else if (state_reg == WR_REQ && !avm_waitrequest && wr_hit)
      line_mem[lat_idx] <= wdata_reg;
  end

endmodule

// File: tb/tb_hps_dma_bridge.sv
// Directed bench for hps_dma_bridge with a 4-word line.
// Each scenario task drives its own stimulus and checks inline.
module tb_hps_dma_bridge;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BURST  = 4;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              dma_rd, dma_wr, flush;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_dout, dma_din;
  logic              io_wait;
  logic [15:0]       hit_cnt;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [6:0]        avm_burstcount;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  int errors = 0;
  int checks = 0;

  hps_dma_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_dout(dma_dout),
    .dma_din(dma_din), .io_wait(io_wait), .flush(flush), .hit_cnt(hit_cnt),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic issue_rd(input logic [31:0] addr);
    dma_rd = 1'b1; dma_addr = addr;
    tick;
    dma_rd = 1'b0;
    $display("txn: read  addr=0x%08h io_wait=%0b avm_read=%0b", addr, io_wait, avm_read);
  endtask

  // Returns one line of beats base+0..base+BURST-1, optional flush and idle gap.
  task automatic send_beats(input logic [31:0] base, input int flush_at, input int gap_at);
    for (int i = 0; i < BURST; i++) begin
      if (i == gap_at) begin
        avm_readdatavalid = 1'b0;
        tick;
      end
      avm_readdatavalid = 1'b1;
      avm_readdata      = base + i;
      flush             = (i == flush_at);
      tick;
    end
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    flush             = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; dma_rd = 0; dma_wr = 0; flush = 0; dma_addr = '0; dma_dout = '0;
    avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
    tick; tick;
    reset = 1'b0;
    checks++; if (io_wait !== 1'b0) begin errors++; $display("FAIL reset_io_wait: got %0b want 0", io_wait); end
    checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL reset_avm_read: got %0b want 0", avm_read); end
    checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL reset_avm_write: got %0b want 0", avm_write); end
    checks++; if (dma_din !== 32'h0) begin errors++; $display("FAIL reset_dma_din: got %08h want 0", dma_din); end
    checks++; if (hit_cnt !== 16'h0) begin errors++; $display("FAIL reset_hit_cnt: got %0h want 0", hit_cnt); end
  endtask

  task automatic test_read_miss;
    avm_waitrequest = 1'b1;
    issue_rd(32'h1008);
    checks++; if (io_wait !== 1'b1) begin errors++; $display("FAIL miss_io_wait: got %0b want 1", io_wait); end
    checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL miss_avm_read: got %0b want 1", avm_read); end
    checks++; if (avm_address !== 32'h1000) begin errors++; $display("FAIL miss_address: got %08h want 00001000", avm_address); end
    checks++; if (avm_burstcount !== 7'd4) begin errors++; $display("FAIL miss_burstcount: got %0d want 4", avm_burstcount); end
    tick;
    checks++; if (avm_read !== 1'b1 || avm_address !== 32'h1000) begin errors++; $display("FAIL miss_hold: read=%0b addr=%08h want 1/00001000", avm_read, avm_address); end
    avm_waitrequest = 1'b0;
    tick;
    checks++; if (avm_read !== 1'b0 || io_wait !== 1'b1) begin errors++; $display("FAIL miss_accept: read=%0b io_wait=%0b want 0/1", avm_read, io_wait); end
    send_beats(32'hA000_0000, -1, 2);
    checks++; if (dma_din !== 32'hA000_0002) begin errors++; $display("FAIL miss_data: got %08h want A0000002", dma_din); end
    checks++; if (io_wait !== 1'b0) begin errors++; $display("FAIL miss_release: got %0b want 0", io_wait); end
    checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL miss_hit_cnt: got %0d want 0", hit_cnt); end
  endtask

  task automatic test_read_hit;
    issue_rd(32'h100C);
    checks++; if (avm_read !== 1'b0 || io_wait !== 1'b0) begin errors++; $display("FAIL hit_quiet: read=%0b io_wait=%0b want 0/0", avm_read, io_wait); end
    checks++; if (dma_din !== 32'hA000_0003) begin errors++; $display("FAIL hit_data: got %08h want A0000003", dma_din); end
    checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL hit_cnt1: got %0d want 1", hit_cnt); end
    issue_rd(32'h1000);
    checks++; if (dma_din !== 32'hA000_0000) begin errors++; $display("FAIL hit_data0: got %08h want A0000000", dma_din); end
    checks++; if (hit_cnt !== 16'd2) begin errors++; $display("FAIL hit_cnt2: got %0d want 2", hit_cnt); end
  endtask

  task automatic test_write_through;
    int wcycles;
    wcycles = 0;
    avm_waitrequest = 1'b1;
    dma_wr = 1'b1; dma_addr = 32'h1004; dma_dout = 32'hDEAD_BEEF;
    tick;
    dma_wr = 1'b0;
    $display("txn: write addr=00001004 data=DEADBEEF");
    checks++; if (avm_burstcount !== 7'd1 || avm_byteenable !== 4'hF) begin errors++; $display("FAIL wr_bc_be: bc=%0d be=%0h want 1/F", avm_burstcount, avm_byteenable); end
    checks++; if (avm_address !== 32'h1004 || avm_writedata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_addr_data: addr=%08h data=%08h want 00001004/DEADBEEF", avm_address, avm_writedata); end
    for (int k = 0; k < 3; k++) begin
      if (avm_write === 1'b1) wcycles++;
      tick;
    end
    avm_waitrequest = 1'b0;
    if (avm_write === 1'b1) wcycles++;
    tick;
    checks++; if (wcycles != 4) begin errors++; $display("FAIL wr_hold_cycles: got %0d want 4", wcycles); end
    checks++; if (avm_write !== 1'b0 || io_wait !== 1'b0) begin errors++; $display("FAIL wr_done: write=%0b io_wait=%0b want 0/0", avm_write, io_wait); end
    issue_rd(32'h1004);
    checks++; if (dma_din !== 32'hDEAD_BEEF || avm_read !== 1'b0) begin errors++; $display("FAIL wr_coherent: got %08h read=%0b want DEADBEEF/0", dma_din, avm_read); end
    issue_rd(32'h1008);
    checks++; if (dma_din !== 32'hA000_0002 || hit_cnt !== 16'd4) begin errors++; $display("FAIL wr_other_word: got %08h cnt=%0d want A0000002/4", dma_din, hit_cnt); end
  endtask

  task automatic test_flush;
    issue_rd(32'h2000);
    checks++; if (avm_read !== 1'b1 || avm_address !== 32'h2000) begin errors++; $display("FAIL fl_miss: read=%0b addr=%08h want 1/00002000", avm_read, avm_address); end
    tick;
    send_beats(32'hB000_0000, 1, -1);
    checks++; if (dma_din !== 32'hB000_0000 || io_wait !== 1'b0) begin errors++; $display("FAIL fl_data: got %08h io_wait=%0b want B0000000/0", dma_din, io_wait); end
    issue_rd(32'h2004);
    checks++; if (avm_read !== 1'b1 || hit_cnt !== 16'd4) begin errors++; $display("FAIL fl_suppressed: read=%0b cnt=%0d want 1/4", avm_read, hit_cnt); end
    tick;
    send_beats(32'hB000_0000, -1, -1);
    checks++; if (dma_din !== 32'hB000_0001) begin errors++; $display("FAIL fl_refetch: got %08h want B0000001", dma_din); end
    flush = 1'b1;
    issue_rd(32'h2008);
    flush = 1'b0;
    checks++; if (avm_read !== 1'b1 || hit_cnt !== 16'd4) begin errors++; $display("FAIL fl_rd_same_cycle: read=%0b cnt=%0d want 1/4", avm_read, hit_cnt); end
    tick;
    send_beats(32'hB000_0000, -1, -1);
    checks++; if (dma_din !== 32'hB000_0002) begin errors++; $display("FAIL fl_rd_data: got %08h want B0000002", dma_din); end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    issue_rd(32'h200C);
    checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL fl_idle: read=%0b want 1", avm_read); end
    tick;
    send_beats(32'hB000_0000, -1, -1);
    checks++; if (dma_din !== 32'hB000_0003 || hit_cnt !== 16'd4) begin errors++; $display("FAIL fl_idle_data: got %08h cnt=%0d want B0000003/4", dma_din, hit_cnt); end
    issue_rd(32'h2004);
    checks++; if (avm_read !== 1'b0 || dma_din !== 32'hB000_0001 || hit_cnt !== 16'd5) begin errors++; $display("FAIL fl_valid_again: read=%0b din=%08h cnt=%0d want 0/B0000001/5", avm_read, dma_din, hit_cnt); end
  endtask

  task automatic test_reset_mid_burst;
    issue_rd(32'h1000);
    tick;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hC000_0000; tick;
    avm_readdata = 32'hC000_0001; tick;
    reset = 1'b1;
    avm_readdata = 32'hC000_0002; tick;
    reset = 1'b0;
    avm_readdata = 32'hC000_0003;
    checks++; if (io_wait !== 1'b0 || avm_read !== 1'b0) begin errors++; $display("FAIL rst_mid: io_wait=%0b read=%0b want 0/0", io_wait, avm_read); end
    checks++; if (dma_din !== 32'h0 || hit_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_regs: din=%08h cnt=%0d want 0/0", dma_din, hit_cnt); end
    tick;
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    checks++; if (io_wait !== 1'b0) begin errors++; $display("FAIL rst_stray_beat: io_wait=%0b want 0", io_wait); end
    issue_rd(32'h2004);
    checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL rst_invalid: read=%0b want 1", avm_read); end
    tick;
    send_beats(32'hB000_0000, -1, -1);
    issue_rd(32'h1000);
    checks++; if (avm_read !== 1'b1 || avm_address !== 32'h1000) begin errors++; $display("FAIL rst_refetch: read=%0b addr=%08h want 1/00001000", avm_read, avm_address); end
    tick;
    send_beats(32'hD000_0000, -1, -1);
    checks++; if (dma_din !== 32'hD000_0000 || hit_cnt !== 16'd0) begin errors++; $display("FAIL rst_refetch_data: got %08h cnt=%0d want D0000000/0", dma_din, hit_cnt); end
  endtask

  task automatic test_back_to_back;
    avm_waitrequest = 1'b1;
    dma_rd = 1'b1; dma_wr = 1'b1; dma_addr = 32'h3000; dma_dout = 32'h1234_5678;
    tick;
    dma_rd = 1'b0; dma_wr = 1'b0;
    $display("txn: rd+wr addr=00003000 data=12345678");
    checks++; if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_address !== 32'h3000) begin errors++; $display("FAIL col_write_wins: wr=%0b rd=%0b addr=%08h want 1/0/00003000", avm_write, avm_read, avm_address); end
    dma_rd = 1'b1; dma_addr = 32'h1000;
    tick;
    dma_rd = 1'b0;
    checks++; if (hit_cnt !== 16'd0 || avm_write !== 1'b1) begin errors++; $display("FAIL busy_ignored: cnt=%0d wr=%0b want 0/1", hit_cnt, avm_write); end
    avm_waitrequest = 1'b0;
    tick;
    checks++; if (avm_write !== 1'b0 || io_wait !== 1'b0 || avm_read !== 1'b0) begin errors++; $display("FAIL col_done: wr=%0b io_wait=%0b rd=%0b want 0/0/0", avm_write, io_wait, avm_read); end
    tick;
    checks++; if (avm_read !== 1'b0 || hit_cnt !== 16'd0) begin errors++; $display("FAIL col_read_dropped: rd=%0b cnt=%0d want 0/0", avm_read, hit_cnt); end
  endtask

  task automatic test_hit_saturation;
    dma_rd = 1'b1; dma_addr = 32'h1004;
    for (int i = 0; i < 65534; i++) tick;
    checks++; if (hit_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_before: got %0h want FFFE", hit_cnt); end
    tick;
    checks++; if (hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %0h want FFFF", hit_cnt); end
    tick; tick; tick;
    dma_rd = 1'b0;
    $display("txn: 65538 back-to-back reads addr=00001004");
    checks++; if (hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0h want FFFF", hit_cnt); end
    checks++; if (dma_din !== 32'hD000_0001 || avm_read !== 1'b0 || io_wait !== 1'b0) begin errors++; $display("FAIL sat_data: din=%08h rd=%0b io_wait=%0b want D0000001/0/0", dma_din, avm_read, io_wait); end
  endtask

  initial begin
    test_reset;
    test_read_miss;
    test_read_hit;
    test_write_through;
    test_flush;
    test_reset_mid_burst;
    test_back_to_back;
    test_hit_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
